// File: rtl/fetch_queue_if.sv
// Fetch-unit bus bundle: icache request/response channel and decode-side handshake.
// master = fetch unit, slave = icache/decode environment.
interface fetch_queue_if #(
    parameter int FETCH_WIDTH = 4,
    parameter int PC_WIDTH    = 32
);
    logic                      ic_req_valid;
    logic                      ic_req_ready;
    logic [PC_WIDTH-1:0]       ic_req_addr;
    logic                      ic_rsp_valid;
    logic [FETCH_WIDTH*32-1:0] ic_rsp_data;
    logic                      dec_valid;
    logic                      dec_ready;
    logic [FETCH_WIDTH*32-1:0] dec_inst;
    logic [FETCH_WIDTH-1:0]    dec_mask;
    logic [PC_WIDTH-1:0]       dec_pc;

    modport master (
        output ic_req_valid, ic_req_addr, dec_valid, dec_inst, dec_mask, dec_pc,
        input  ic_req_ready, ic_rsp_valid, ic_rsp_data, dec_ready
    );
    modport slave (
        input  ic_req_valid, ic_req_addr, dec_valid, dec_inst, dec_mask, dec_pc,
        output ic_req_ready, ic_rsp_valid, ic_rsp_data, dec_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC sequencing, credit-limited icache requests, fetch queue to decode.
// Optional macro FETCH_PERF_CNT_EN adds saturating performance counters.
module fetch_queue_unit #(
    parameter int                  FETCH_WIDTH     = 4,
    parameter int                  PC_WIDTH        = 32,
    parameter int                  FQ_DEPTH        = 8,
    parameter int                  MAX_OUTSTANDING = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [PC_WIDTH-1:0]            flush_pc,
    input  logic                           bp_taken,
    input  logic [$clog2(FETCH_WIDTH)-1:0] bp_slot,
    input  logic [PC_WIDTH-1:0]            bp_target,
    fetch_queue_if.master                  fq_if
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_fq_full_cycles,
    output logic [31:0]                    perf_dropped_rsp,
    output logic [31:0]                    perf_redirects
`endif
);
    localparam int OFF_W = $clog2(FETCH_WIDTH);
    localparam int BB_W  = OFF_W + 2;
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CW1   = CNT_W + 1;
    localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SP_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int DW    = FETCH_WIDTH * 32;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [FETCH_WIDTH-1:0] mask;
    } side_t;

    typedef struct packed {
        logic [DW-1:0] data;
        side_t         tag;
    } fq_ent_t;

    logic [PC_WIDTH-1:0] pc;
    logic [OST_W-1:0]    ost, drop;
    logic [CNT_W-1:0]    fq_cnt;
    logic [PTR_W-1:0]    fq_wr, fq_rd;
    logic [SP_W-1:0]     sp_wr, sp_rd;
    side_t               side_mem [MAX_OUTSTANDING];
    fq_ent_t             fq_mem   [FQ_DEPTH];

    function automatic logic [SP_W-1:0] sp_inc(input logic [SP_W-1:0] p);
        return (p == SP_W'(MAX_OUTSTANDING - 1)) ? '0 : p + SP_W'(1);
    endfunction

    logic [OFF_W-1:0]       off;
    logic [PC_WIDTH-1:0]    pc_aligned;
    logic                   bp_use;
    logic [FETCH_WIDTH-1:0] req_mask;
    logic [OST_W-1:0]       live;
    logic [CW1-1:0]         credit_used;
    logic                   req_valid, req_fire, rsp_keep, pop;
    fq_ent_t                head;

    assign off        = pc[BB_W-1:2];
    assign pc_aligned = {pc[PC_WIDTH-1:BB_W], BB_W'(0)};
    // A prediction on a lane before the entry offset cannot be the taken branch.
    assign bp_use     = bp_taken && (bp_slot >= off);

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
        assign req_mask[i] = (OFF_W'(i) >= off) && (!bp_use || (OFF_W'(i) <= bp_slot));
    end

    // Every live request holds a reserved queue slot, so responses never stall.
    assign live        = ost - drop;
    assign credit_used = CW1'(fq_cnt) + CW1'(live);
    assign req_valid   = rst_n && !flush && (credit_used < CW1'(FQ_DEPTH)) &&
                         (ost < OST_W'(MAX_OUTSTANDING));
    assign req_fire    = req_valid && fq_if.ic_req_ready;
    assign rsp_keep    = fq_if.ic_rsp_valid && !flush && (drop == '0);
    assign pop         = (fq_cnt != '0) && fq_if.dec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            ost    <= '0;
            drop   <= '0;
            fq_cnt <= '0;
            fq_wr  <= '0;
            fq_rd  <= '0;
            sp_wr  <= '0;
            sp_rd  <= '0;
        end else if (flush) begin
            pc     <= flush_pc;
            ost    <= ost - OST_W'(fq_if.ic_rsp_valid);
            drop   <= ost - OST_W'(fq_if.ic_rsp_valid);
            fq_cnt <= '0;
            fq_wr  <= '0;
            fq_rd  <= '0;
            sp_wr  <= '0;
            sp_rd  <= '0;
        end else begin
            if (req_fire) begin
                pc    <= bp_use ? bp_target : pc_aligned + PC_WIDTH'(FETCH_WIDTH * 4);
                sp_wr <= sp_inc(sp_wr);
            end
            ost <= ost + OST_W'(req_fire) - OST_W'(fq_if.ic_rsp_valid);
            if (fq_if.ic_rsp_valid && (drop != '0))
                drop <= drop - OST_W'(1);
            if (rsp_keep) begin
                sp_rd <= sp_inc(sp_rd);
                fq_wr <= fq_wr + PTR_W'(1);
            end
            if (pop)
                fq_rd <= fq_rd + PTR_W'(1);
            fq_cnt <= fq_cnt + CNT_W'(rsp_keep) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            side_mem[sp_wr] <= '{pc: pc, mask: req_mask};
        if (rsp_keep)
            fq_mem[fq_wr] <= '{data: fq_if.ic_rsp_data, tag: side_mem[sp_rd]};
    end

    assign head               = fq_mem[fq_rd];
    assign fq_if.ic_req_valid = req_valid;
    assign fq_if.ic_req_addr  = pc_aligned;
    assign fq_if.dec_valid    = (fq_cnt != '0);
    assign fq_if.dec_inst     = fq_if.dec_valid ? head.data     : '0;
    assign fq_if.dec_mask     = fq_if.dec_valid ? head.tag.mask : '0;
    assign fq_if.dec_pc       = fq_if.dec_valid ? head.tag.pc   : '0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fq_full_cycles <= '0;
            perf_dropped_rsp    <= '0;
            perf_redirects      <= '0;
        end else begin
            if ((fq_cnt == CNT_W'(FQ_DEPTH)) && (perf_fq_full_cycles != '1))
                perf_fq_full_cycles <= perf_fq_full_cycles + 32'd1;
            if (fq_if.ic_rsp_valid && !rsp_keep && (perf_dropped_rsp != '1))
                perf_dropped_rsp <= perf_dropped_rsp + 32'd1;
            if ((flush || (req_fire && bp_taken)) && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: icache model, queue-based reference model, vector table and corner sequences.
module tb_fetch_queue_unit;
    localparam int FW = 4, PW = 32, DEPTH = 8, MAXO = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 0, rst_n = 0, flush = 0, bp_taken = 0;
    logic [31:0] flush_pc = 0, bp_target = 0;
    logic [1:0]  bp_slot = 0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_full, perf_drop, perf_redir;
`endif

    fetch_queue_if #(.FETCH_WIDTH(FW), .PC_WIDTH(PW)) bus ();

    fetch_queue_unit #(.FETCH_WIDTH(FW), .PC_WIDTH(PW), .FQ_DEPTH(DEPTH),
                       .MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .bp_taken(bp_taken), .bp_slot(bp_slot), .bp_target(bp_target), .fq_if(bus)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fq_full_cycles(perf_full), .perf_dropped_rsp(perf_drop), .perf_redirects(perf_redir)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [3:0] mask; bit killed; } infl_t;
    typedef struct { logic [31:0] pc; logic [3:0] mask; logic [127:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; bit tk; logic [1:0] slot; logic [31:0] tgt;
                     logic [3:0] exp_mask; logic [31:0] exp_next; } vec_t;

    infl_t infl[$];
    ent_t  fq[$];
    pend_t pend[$];
    logic [31:0] m_pc, req_log[$];
    int cyc, lat = 2, checks = 0, errors = 0;
    logic s_rv, s_dv;
    logic [31:0] s_addr, s_pc;
    logic [3:0] s_mask;
    logic [127:0] s_inst;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] data_of(input logic [31:0] a);
        logic [127:0] d;
        for (int i = 0; i < FW; i++) d[32*i +: 32] = (a + 32'(4*i)) ^ 32'hA5A5_0000;
        return d;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return a - (a % 32'd16);
    endfunction

    function automatic bit bp_applies(input logic [31:0] pc, input bit tk, input int slot);
        return tk && (slot >= int'((pc % 32'd16) / 32'd4));
    endfunction

    function automatic logic [3:0] mask_of(input logic [31:0] pc, input bit tk, input int slot);
        logic [3:0] m;
        int off;
        off = int'((pc % 32'd16) / 32'd4);
        for (int i = 0; i < FW; i++)
            m[i] = (i >= off) && (!bp_applies(pc, tk, slot) || i <= slot);
        return m;
    endfunction

    // One clock: present icache response, compare at negedge, advance model after posedge.
    task automatic cycle();
        int live, d;
        logic exp_rv;
        ent_t head;
        bit hs, pop, rsp;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.ic_rsp_valid = 1; bus.ic_rsp_data = data_of(pend[0].addr);
        end else begin
            bus.ic_rsp_valid = 0; bus.ic_rsp_data = '0;
        end
        @(negedge clk);
        s_rv = bus.ic_req_valid; s_addr = bus.ic_req_addr; s_dv = bus.dec_valid;
        s_pc = bus.dec_pc; s_mask = bus.dec_mask; s_inst = bus.dec_inst;
        live = 0;
        foreach (infl[i]) if (!infl[i].killed) live++;
        exp_rv = !flush && (fq.size() + live < DEPTH) && (infl.size() < MAXO);
        check("ic_req_valid", 128'(s_rv), 128'(exp_rv));
        if (exp_rv) check("ic_req_addr", 128'(s_addr), 128'(align(m_pc)));
        if (fq.size() > 0) head = fq[0]; else head = '{default: 0};
        check("dec_valid", 128'(s_dv), 128'(fq.size() > 0));
        check("dec_pc", 128'(s_pc), 128'(head.pc));
        check("dec_mask", 128'(s_mask), 128'(head.mask));
        check("dec_inst", s_inst, head.data);
        hs = exp_rv && bus.ic_req_ready;
        pop = (fq.size() > 0) && bus.dec_ready;
        rsp = bus.ic_rsp_valid;
        @(posedge clk); #1;
        if (rsp) pend.delete(0);
        if (flush) begin
            if (rsp && infl.size() > 0) infl.delete(0);
            foreach (infl[i]) infl[i].killed = 1;
            fq.delete();
            m_pc = flush_pc;
        end else begin
            if (pop) fq.delete(0);
            if (rsp && infl.size() > 0) begin
                if (!infl[0].killed)
                    fq.push_back('{infl[0].pc, infl[0].mask, data_of(align(infl[0].pc))});
                infl.delete(0);
            end
            if (hs) begin
                infl.push_back('{m_pc, mask_of(m_pc, bp_taken, int'(bp_slot)), 0});
                d = cyc + lat;
                if (pend.size() > 0 && pend[$].due >= d) d = pend[$].due + 1;
                pend.push_back('{align(m_pc), d});
                req_log.push_back(align(m_pc));
                m_pc = bp_applies(m_pc, bp_taken, int'(bp_slot)) ? bp_target : align(m_pc) + 32'd16;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        check("rst ic_req_valid", 128'(bus.ic_req_valid), 128'(0));
        check("rst dec_valid", 128'(bus.dec_valid), 128'(0));
        check("rst dec_mask", 128'(bus.dec_mask), 128'(0));
        check("rst dec_pc", 128'(bus.dec_pc), 128'(0));
        check("rst dec_inst", bus.dec_inst, 128'(0));
        infl.delete(); fq.delete(); pend.delete();
        m_pc = RST_PC; flush = 0; bus.ic_rsp_valid = 0;
        @(posedge clk); #1;
        rst_n = 1; cyc = 0;
    endtask

    task automatic drain();
        int n = 0;
        bus.ic_req_ready = 0; bus.dec_ready = 1; flush = 0; bp_taken = 0;
        while ((infl.size() > 0 || fq.size() > 0) && n < 100) begin cycle(); n++; end
        cycle();
        check("drain dec_valid", 128'(s_dv), 128'(0));
    endtask

    vec_t vecs[6];
    int first, pops, nhs, fcyc, n;

    initial begin
        vecs[0] = '{32'h108, 1, 2'd3, 32'h204, 4'b1100, 32'h200};
        vecs[1] = '{32'h204, 0, 2'd0, 32'h0,   4'b1110, 32'h210};
        vecs[2] = '{32'h100, 1, 2'd1, 32'h300, 4'b0011, 32'h300};
        vecs[3] = '{32'h10C, 1, 2'd1, 32'h500, 4'b1000, 32'h110};
        vecs[4] = '{32'hFFFF_FFF8, 0, 2'd0, 32'h0, 4'b1100, 32'h0};
        vecs[5] = '{32'h34,  1, 2'd1, 32'h80,  4'b0010, 32'h80};
        bus.ic_req_ready = 0; bus.dec_ready = 0; bus.ic_rsp_valid = 0; bus.ic_rsp_data = '0;
        @(posedge clk); #1;
        do_reset();

        // Sequential fetch from reset with a 2-cycle icache
        bus.ic_req_ready = 1; bus.dec_ready = 1; req_log.delete(); first = -1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (first < 0 && s_dv) begin
                first = cyc - 1;
                check("seq first dec_pc", 128'(s_pc), 128'(0));
                check("seq first dec_mask", 128'(s_mask), 128'(4'b1111));
            end
        end
        check("seq first dec_valid cycle", 128'(first), 128'(3));
        check("seq req0", 128'(req_log[0]), 128'(32'h0));
        check("seq req1", 128'(req_log[1]), 128'(32'h10));
        check("seq req2", 128'(req_log[2]), 128'(32'h20));

        // Entry offset / prediction vectors
        for (int v = 0; v < 6; v++) begin
            drain();
            flush = 1; flush_pc = vecs[v].pc; cycle(); flush = 0;
            bus.ic_req_ready = 1; bp_taken = vecs[v].tk; bp_slot = vecs[v].slot;
            bp_target = vecs[v].tgt; cycle();
            bus.ic_req_ready = 0; bp_taken = 0; cycle();
            check("vec next addr", 128'(s_addr), 128'(vecs[v].exp_next));
            for (n = 0; n < 20 && !s_dv; n++) cycle();
            check("vec dec_valid", 128'(s_dv), 128'(1));
            check("vec dec_mask", 128'(s_mask), 128'(vecs[v].exp_mask));
            check("vec dec_pc", 128'(s_pc), 128'(vecs[v].pc));
        end

        // Decode backpressure fills the queue, then drains with no loss
        drain(); lat = 2;
        bus.dec_ready = 0; bus.ic_req_ready = 1;
        for (int i = 0; i < 20; i++) cycle();
        check("bp req stalled", 128'(s_rv), 128'(0));
        bus.ic_req_ready = 0; bus.dec_ready = 1; pops = 0;
        for (int i = 0; i < 8; i++) begin cycle(); if (s_dv) pops++; end
        cycle();
        check("bp pops", 128'(pops), 128'(8));
        check("bp empty", 128'(s_dv), 128'(0));

        // Flush with three requests in flight returning 1, 2 and 5 cycles later
        drain(); lat = 50;
        bus.ic_req_ready = 1;
        for (int i = 0; i < 3; i++) cycle();
        bus.ic_req_ready = 0; cycle();
        flush = 1; flush_pc = 32'h400; fcyc = cyc; cycle(); flush = 0;
        pend[0].due = fcyc + 1; pend[1].due = fcyc + 2; pend[2].due = fcyc + 5;
        lat = 2; bus.ic_req_ready = 1;
        for (n = 0; n < 30 && !s_dv; n++) cycle();
        check("flush3 dec_valid", 128'(s_dv), 128'(1));
        check("flush3 dec_pc", 128'(s_pc), 128'(32'h400));

        // Flush while the queue is full and popping
        drain();
        bus.dec_ready = 0; bus.ic_req_ready = 1;
        for (int i = 0; i < 15; i++) cycle();
        bus.ic_req_ready = 0; cycle();
        check("full dec_valid", 128'(s_dv), 128'(1));
        bus.dec_ready = 1; flush = 1; flush_pc = 32'h800; cycle(); flush = 0;
        cycle();
        check("full flush empty", 128'(s_dv), 128'(0));

        // Flush coincident with a response
        drain(); lat = 40;
        bus.ic_req_ready = 1; cycle();
        bus.ic_req_ready = 0; cycle();
        pend[0].due = cyc;
        flush = 1; flush_pc = 32'hC00; cycle(); flush = 0;
        bus.ic_req_ready = 1; bus.dec_ready = 0; nhs = 0;
        cycle();
        check("rspflush req_valid", 128'(s_rv), 128'(1));
        check("rspflush req_addr", 128'(s_addr), 128'(32'hC00));
        nhs += int'(s_rv);
        for (int i = 0; i < 5; i++) begin cycle(); nhs += int'(s_rv); end
        check("rspflush credits", 128'(nhs), 128'(MAXO));
        drain();

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 6);
            bus.ic_req_ready = ($urandom_range(0, 3) != 0);
            bus.dec_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
            flush_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                                   : ($urandom & ~32'h3);
            bp_taken = ($urandom_range(0, 3) == 0);
            bp_slot = 2'($urandom_range(0, 3));
            bp_target = $urandom & ~32'h3;
            cycle();
        end
        flush = 0; bp_taken = 0;

        // Asynchronous reset mid-stream, then restart at the reset PC
        bus.ic_req_ready = 1; bus.dec_ready = 1; lat = 2;
        for (int i = 0; i < 6; i++) cycle();
        do_reset();
        cycle();
        check("restart req_valid", 128'(s_rv), 128'(1));
        check("restart req_addr", 128'(s_addr), 128'(RST_PC));
        for (int i = 0; i < 8; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Next-generation instruction fetch stage. It keeps the fetch PC and issues bundle-aligned requests to a variable-latency, in-order icache through a valid/ready handshake. Returned bundles are buffered in a parametrised fetch queue, with a per-lane valid mask for unaligned entry and predicted-taken branches. Decode consumes bundles through a valid/ready handshake, and flush discards both queued and in-flight fetches.

Parameters:
FETCH_WIDTH, 4, instructions per bundle (power of 2, ≥2)
PC_WIDTH, 32, byte-address width
FQ_DEPTH, 8, fetch-queue entries (power of 2, ≥2)
MAX_OUTSTANDING, 4, maximum icache requests in flight (≤ FQ_DEPTH)
RESET_PC, 0, PC after reset (byte address, 4-byte aligned)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  redirect; kills queue and in-flight fetches
flush_pc  in  PC_WIDTH  new fetch PC on flush
bp_taken  in  1  prediction for the bundle at current fetch PC
bp_slot  in  $clog2(FETCH_WIDTH)  lane holding the predicted-taken branch
bp_target  in  PC_WIDTH  predicted target
ic_req_valid  out  1  request valid
ic_req_ready  in  1  icache accepts request
ic_req_addr  out  PC_WIDTH  bundle-aligned address (low log2(FETCH_WIDTH*4) bits zero)
ic_rsp_valid  in  1  response valid (in order, no backpressure)
ic_rsp_data  in  FETCH_WIDTH*32  bundle; lane i at bits [32i+31:32i]
dec_valid  out  1  queue head valid
dec_ready  in  1  decode accepts head
dec_inst  out  FETCH_WIDTH*32  head bundle
dec_mask  out  FETCH_WIDTH  per-lane valid
dec_pc  out  PC_WIDTH  PC of first valid lane of head

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low.
- Reset values:
  - fetch PC = RESET_PC
  - queue empty; outstanding = 0; drop_cnt = 0
  - ic_req_valid = 0, dec_valid = 0, dec_mask = 0, dec_pc = 0, dec_inst = 0
- Definitions:
  - BB = FETCH_WIDTH*4 bytes per bundle.
  - off = (PC mod BB)/4.
  - live = outstanding − drop_cnt.
- Request issue: ic_req_valid = !flush && (fq_count + live < FQ_DEPTH) && (outstanding < MAX_OUTSTANDING).
  - ic_req_addr = PC with low bits cleared.
  - ic_req_valid and ic_req_addr stay stable while waiting for ready, except when flush occurs.
- Request handshake (valid && ready):
  - PC ← bp_taken ? bp_target : aligned(PC) + BB, wrapping modulo 2^PC_WIDTH.
  - Push (pc = PC, mask) into a side FIFO of MAX_OUTSTANDING entries.
  - mask lane i = (i ≥ off) && (!bp_taken || i ≤ bp_slot).
  - If bp_taken with bp_slot < off, the prediction is ignored: sequential next PC, mask unchanged.
- Credit accounting guarantees queue space for every live response, so there is no response backpressure.
- Response handling:
  - If flush is high or drop_cnt > 0: discard the response; decrement drop_cnt unless flush is high.
  - Otherwise: pop the side FIFO and write {data, pc, mask} into the fetch queue.
  - Every response decrements outstanding.
- Decode handshake: head valid when queue non-empty.
  - dec_* driven combinationally from head; head pops on dec_valid && dec_ready.
  - Enqueue and dequeue in the same cycle are allowed, including when the queue is full (count unchanged).
- Flush (takes priority over every other event that cycle):
  - Queue and side FIFO cleared; PC ← flush_pc.
  - drop_cnt ← outstanding − ic_rsp_valid; outstanding ← outstanding − ic_rsp_valid.
  - No request issued in the flush cycle; dec_valid = 0 from the next cycle.
  - A second flush while drop_cnt > 0 recomputes drop_cnt by the same rule.
- Latency: minimum one cycle from response to dec_valid (registered queue write); no combinational path from ic_rsp to dec_*.
- Pointers: wrap modulo FQ_DEPTH; count is width $clog2(FQ_DEPTH)+1.
- Async reset mid-operation: all state returns to reset values immediately; the icache is required to drop in-flight requests on the same reset.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fq_full_cycles (32-bit), perf_dropped_rsp (32-bit) and perf_redirects (32-bit).
  - perf_fq_full_cycles counts cycles with fq_count == FQ_DEPTH.
  - perf_dropped_rsp counts discarded responses.
  - perf_redirects counts flush cycles plus accepted bp_taken requests.
  - All reset to 0 and saturate at all-ones.
- Not defined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Sequential: reset, ic_req_ready = 1, 2-cycle icache, dec_ready = 1 → ic_req_addr 0x0, 0x10, 0x20…; dec_pc matches in order; dec_mask = 4'b1111; first dec_valid 3 cycles after reset release.
- Unaligned + branch: flush_pc = 0x108; bundle 0x100 returned with bp_taken = 1, bp_slot = 3, bp_target = 0x204 → dec_mask = 4'b1100, dec_pc = 0x108; next request 0x200; next mask = 4'b1110, dec_pc = 0x204.
- Backpressure: dec_ready = 0 for 20 cycles → at most FQ_DEPTH = 8 bundles queued, then ic_req_valid = 0; release → 8 consecutive pops, no loss or duplicates.
- Flush with 3 in flight: responses arrive 1, 2 and 5 cycles after a flush to 0x400 → all 3 dropped; first dec_pc = 0x400.
- Flush coincident with response and with a full-queue pop → response dropped, queue empty next cycle, outstanding consistent.
- Async reset asserted mid-stream, off a clock edge → ic_req_valid and dec_valid drop immediately; after release, fetch restarts at RESET_PC.
